axi_lite_rd_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI-lite slave read port among NUM_MASTERS AXI-lite read requesters. It sits between the requester-side read channels (AR/R) and a single downstream AXI-lite slave. It allows one transaction in flight at a time and locks the grant from arbitration until the R handshake completes. Write channels are out of scope for this block.

---
 rtl/axi_lite_rd_arbiter.sv | 67 ++++++
 tb/tb_axi_lite_rd_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_rd_arbiter.sv
// axi_lite_rd_arbiter: round-robin share of one AXI-lite read port, one transaction in flight
module axi_lite_rd_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_MASTERS-1:0]            s_arvalid,
  output logic [NUM_MASTERS-1:0]            s_arready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_MASTERS*3-1:0]          s_arprot,
  output logic [NUM_MASTERS-1:0]            s_rvalid,
  input  logic [NUM_MASTERS-1:0]            s_rready,
  output logic [DATA_WIDTH-1:0]             s_rdata,
  output logic [1:0]                        s_rresp,
  output logic                              m_arvalid,
  input  logic                              m_arready,
  output logic [ADDR_WIDTH-1:0]             m_araddr,
  output logic [2:0]                        m_arprot,
  input  logic                              m_rvalid,
  output logic                              m_rready,
  input  logic [DATA_WIDTH-1:0]             m_rdata,
  input  logic [1:0]                        m_rresp,
  output logic                              grant_valid,
  output logic [GW-1:0]                     grant
);
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2;
  logic [1:0] state;
  logic [GW-1:0] last_grant, nxt;
  logic [NUM_MASTERS-1:0] sel;
  // Scan downward so the nearest requester after last_grant is assigned last and wins
  always_comb begin
    nxt = last_grant;
    for (int k = NUM_MASTERS; k >= 1; k--)
      if (s_arvalid[(int'(last_grant) + k) % NUM_MASTERS])
        nxt = GW'((int'(last_grant) + k) % NUM_MASTERS);
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= GW'(NUM_MASTERS - 1);
    end else if (state == IDLE) begin
      if (|s_arvalid) begin
        grant <= nxt;
        state <= ADDR;
      end
    end else if (state == ADDR) begin
      if (m_arvalid && m_arready) state <= DATA;
    end else if (m_rvalid && m_rready) begin
      last_grant <= grant;
      state <= IDLE;
    end
  end
  assign sel = NUM_MASTERS'(1) << grant;
  assign grant_valid = (state == ADDR) || (state == DATA);
  assign m_arvalid = (state == ADDR) && s_arvalid[grant];
  assign s_arready = ((state == ADDR) && m_arready) ? sel : '0;
  assign m_rready = (state == DATA) && s_rready[grant];
  assign s_rvalid = ((state == DATA) && m_rvalid) ? sel : '0;
  assign m_araddr = s_araddr[grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_arprot = s_arprot[grant*3 +: 3];
  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// tb_axi_lite_rd_arbiter: directed checks of the read arbiter with 2 and 4 requesters
module tb_axi_lite_rd_arbiter;
  logic aclk = 0, aresetn = 0;
  always #5 aclk = ~aclk;
  logic [1:0] s_arvalid = 0, s_arready, s_rvalid, s_rready = 0;
  logic [63:0] s_araddr = 0;
  logic [5:0] s_arprot = 0;
  logic [31:0] s_rdata, m_araddr, m_rdata = 0;
  logic [1:0] s_rresp, m_rresp = 0;
  logic m_arvalid, m_arready = 0, m_rvalid = 0, m_rready, grant_valid;
  logic [2:0] m_arprot;
  logic [0:0] grant;
  axi_lite_rd_arbiter #(.NUM_MASTERS(2)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .grant_valid(grant_valid), .grant(grant));
  logic [3:0] a4_valid = 0, a4_ready, r4_valid, r4_ready = 4'hf;
  logic [127:0] a4_addr = {32'h30, 32'h20, 32'h10, 32'h00};
  logic [11:0] a4_prot = 0;
  logic [31:0] r4_data, m4_araddr;
  logic [1:0] r4_resp;
  logic m4_arvalid, m4_rready, gv4;
  logic [2:0] m4_arprot;
  logic [1:0] grant4;
  axi_lite_rd_arbiter #(.NUM_MASTERS(4)) dut4 (
    .aclk(aclk), .aresetn(aresetn), .s_arvalid(a4_valid), .s_arready(a4_ready),
    .s_araddr(a4_addr), .s_arprot(a4_prot), .s_rvalid(r4_valid), .s_rready(r4_ready),
    .s_rdata(r4_data), .s_rresp(r4_resp), .m_arvalid(m4_arvalid), .m_arready(1'b1),
    .m_araddr(m4_araddr), .m_arprot(m4_arprot), .m_rvalid(1'b1), .m_rready(m4_rready),
    .m_rdata(32'h0), .m_rresp(2'b00), .grant_valid(gv4), .grant(grant4));
  int checks = 0, errors = 0, ar_hs = 0, r_hs = 0, ar0, r0;
  always @(posedge aclk) begin
    if (m_arvalid && m_arready) ar_hs++;
    if (m_rvalid && m_rready) r_hs++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge aclk);
    #1;
  endtask
  task automatic idle_outs(input string tag);
    #1;
    check({tag, "_gv"}, grant_valid, 0);
    check({tag, "_outs"}, {m_arvalid, m_rready, s_arready, s_rvalid}, 0);
  endtask
  logic [1:0] exp4 [5] = '{0, 2, 3, 0, 3};
  initial begin
    tick;
    tick;
    idle_outs("rst");
    check("rst_grant", grant, 0);
    aresetn = 1;
    s_araddr = {32'h40, 32'h0};
    s_arvalid = 2'b10;
    tick;
    #1;
    check("single_arvalid", m_arvalid, 1);
    check("single_addr", m_araddr, 32'h40);
    check("single_grant", grant, 1);
    m_arready = 1;
    #1;
    check("single_arready", s_arready, 2'b10);
    tick;
    m_arready = 0;
    s_arvalid = 0;
    m_rvalid = 1;
    m_rdata = 32'hDEADBEEF;
    s_rready = 2'b10;
    #1;
    check("single_rvalid", s_rvalid, 2'b10);
    check("single_rdata", s_rdata, 32'hDEADBEEF);
    check("single_rready", m_rready, 1);
    tick;
    m_rvalid = 0;
    idle_outs("single_end");
    check("single_grant_hold", grant, 1);
    s_arvalid = 2'b11;
    s_araddr = {32'h4, 32'h0};
    s_rready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick;
      #1;
      check("cont_grant", grant, i % 2);
      check("cont_addr", m_araddr, (i % 2) * 4);
      m_arready = 1;
      #1;
      check("cont_arready", s_arready, 2'b01 << (i % 2));
      tick;
      m_arready = 0;
      m_rvalid = 1;
      m_rdata = 32'hA0 + i;
      #1;
      check("cont_rvalid", s_rvalid, 2'b01 << (i % 2));
      check("cont_rdata", s_rdata, 32'hA0 + i);
      tick;
      m_rvalid = 0;
    end
    s_arvalid = 2'b01;
    s_rready = 0;
    ar0 = ar_hs;
    r0 = r_hs;
    tick;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_addr_hold", {grant_valid, m_arvalid, s_arready, 1'(grant)}, 5'b11000);
      tick;
    end
    m_arready = 1;
    tick;
    m_arready = 0;
    s_arvalid = 0;
    m_rvalid = 1;
    m_rdata = 32'h5A5A;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_data_hold", {grant_valid, m_rready, s_rvalid, 1'(grant)}, 5'b10010);
      tick;
    end
    s_rready = 2'b01;
    tick;
    m_rvalid = 0;
    idle_outs("bp_end");
    check("bp_ar_hs", ar_hs - ar0, 1);
    check("bp_r_hs", r_hs - r0, 1);
    s_arvalid = 2'b10;
    tick;
    m_arready = 1;
    tick;
    m_arready = 0;
    s_arvalid = 0;
    m_rvalid = 1;
    m_rresp = 2'b10;
    s_rready = 2'b10;
    #1;
    check("err_rresp", s_rresp, 2'b10);
    check("err_rvalid", s_rvalid, 2'b10);
    tick;
    m_rvalid = 0;
    m_rresp = 0;
    idle_outs("err_end");
    s_arvalid = 2'b01;
    tick;
    m_arready = 1;
    tick;
    m_arready = 0;
    s_arvalid = 0;
    #1;
    check("rst_mid_data", grant_valid, 1);
    aresetn = 0;
    tick;
    aresetn = 1;
    idle_outs("rst_mid");
    check("rst_mid_grant", grant, 0);
    s_arvalid = 2'b11;
    tick;
    #1;
    check("rst_both_grant", grant, 0);
    aresetn = 0;
    s_arvalid = 2'b10;
    tick;
    aresetn = 1;
    tick;
    #1;
    check("rst_sole_grant", grant, 1);
    aresetn = 0;
    s_arvalid = 0;
    tick;
    aresetn = 1;
    a4_valid = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      tick;
      #1;
      check("fair_grant", grant4, exp4[i]);
      check("fair_addr", m4_araddr, exp4[i] * 32'h10);
      tick;
      if (grant4 == 2) a4_valid[2] = 0;
      tick;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
